rs_param_issue: RTL

//   Parametrised reservation station for the ALU/branch path; it succeeds the fixed 16-entry RS.
//   - Holds up to DEPTH dispatched ops until both operands are ready.
//   - Wakes operands from NUM_CDB result buses, with same-cycle bypass on dispatch.
//   - Issues one ready op per cycle to the ALU through a valid/ready handshake with backpressure.
//   - Sits between the decoder/dispatch stage and RS_EX. Its full flag stalls the fetcher.

---
 rtl/rs_param_issue_if.sv | 44 ++++
 rtl/rs_param_issue.sv | 131 +++++++++++++
 2 files changed

// File: rtl/rs_param_issue_if.sv
// rs_param_issue_if: dispatch, CDB wakeup and issue-port bundle for rs_param_issue.
// master drives dispatch/CDB/iss_ready; slave is the reservation station.
interface rs_param_issue_if #(
    parameter int DEPTH   = 16,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2,
    parameter int OP_W    = 6
);
    logic                     rdy;
    logic                     flush;
    logic                     disp_en;
    logic [OP_W-1:0]          disp_op;
    logic [31:0]              disp_v1;
    logic [31:0]              disp_v2;
    logic [ROB_W-1:0]         disp_q1;
    logic [ROB_W-1:0]         disp_q2;
    logic [31:0]              disp_pc;
    logic [31:0]              disp_imm;
    logic [ROB_W-1:0]         disp_rob;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob;
    logic [NUM_CDB*32-1:0]    cdb_data;
    logic                     iss_valid;
    logic                     iss_ready;
    logic [OP_W-1:0]          iss_op;
    logic [31:0]              iss_v1;
    logic [31:0]              iss_v2;
    logic [31:0]              iss_pc;
    logic [31:0]              iss_imm;
    logic [ROB_W-1:0]         iss_rob;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output rdy, flush, disp_en, disp_op, disp_v1, disp_v2, disp_q1, disp_q2,
               disp_pc, disp_imm, disp_rob, cdb_valid, cdb_rob, cdb_data, iss_ready,
        input  iss_valid, iss_op, iss_v1, iss_v2, iss_pc, iss_imm, iss_rob, full, count
    );
    modport slave (
        input  rdy, flush, disp_en, disp_op, disp_v1, disp_v2, disp_q1, disp_q2,
               disp_pc, disp_imm, disp_rob, cdb_valid, cdb_rob, cdb_data, iss_ready,
        output iss_valid, iss_op, iss_v1, iss_v2, iss_pc, iss_imm, iss_rob, full, count
    );
endinterface

// File: rtl/rs_param_issue.sv
// rs_param_issue: parametrised reservation station with CDB wakeup and a registered issue slot.
// Define RS_AGE_ISSUE_EN for oldest-first selection; otherwise the lowest-index ready entry issues.
module rs_param_issue #(
    parameter int DEPTH   = 16,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2,
    parameter int OP_W    = 6
) (
    input logic         clk,
    input logic         rst,
    rs_param_issue_if.slave rs
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] pick;
    logic [OP_W-1:0]  e_op  [DEPTH];
    logic [31:0]      e_v1  [DEPTH];
    logic [31:0]      e_v2  [DEPTH];
    logic [31:0]      e_pc  [DEPTH];
    logic [31:0]      e_imm [DEPTH];
    logic [ROB_W-1:0] e_q1  [DEPTH];
    logic [ROB_W-1:0] e_q2  [DEPTH];
    logic [ROB_W-1:0] e_rob [DEPTH];
    logic [32:0]      w1    [DEPTH];
    logic [32:0]      w2    [DEPTH];
    logic [32:0]      b1;
    logic [32:0]      b2;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    fs;
    logic             drain;
    logic             load;
    logic             acc;

    // {hit, data} for a tag; iterating downward lets the lowest bus index win
    function automatic logic [32:0] snoop(input logic [ROB_W-1:0] q, input logic [NUM_CDB-1:0] v,
                                          input logic [NUM_CDB*ROB_W-1:0] r,
                                          input logic [NUM_CDB*32-1:0] d);
        snoop = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--)
            if (q != '0 && v[k] && r[k*ROB_W +: ROB_W] == q) snoop = {1'b1, d[k*32 +: 32]};
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy[i] && e_q1[i] == '0 && e_q2[i] == '0;
            w1[i] = snoop(e_q1[i], rs.cdb_valid, rs.cdb_rob, rs.cdb_data);
            w2[i] = snoop(e_q2[i], rs.cdb_valid, rs.cdb_rob, rs.cdb_data);
        end
        b1 = snoop(rs.disp_q1, rs.cdb_valid, rs.cdb_rob, rs.cdb_data);
        b2 = snoop(rs.disp_q2, rs.cdb_valid, rs.cdb_rob, rs.cdb_data);
    end

`ifdef RS_AGE_ISSUE_EN
    // age[i][j] set means entry j was already waiting when entry i arrived
    logic [DEPTH-1:0] age [DEPTH];

    always_comb
        for (int i = 0; i < DEPTH; i++) pick[i] = ready[i] && !(|(age[i] & ready));

    always_ff @(posedge clk)
        if (rst && !rs.flush && acc) begin
            age[fs] <= busy;
            for (int r = 0; r < DEPTH; r++) age[r][fs] <= 1'b0;
        end
`else
    assign pick = ready;
`endif

    always_comb begin
        sel = '0;
        fs  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (pick[i]) sel = IW'(i);
            if (!busy[i]) fs = IW'(i);
        end
    end

    assign rs.full = rs.count == CW'(DEPTH);
    assign drain   = !rs.iss_valid || rs.iss_ready;
    assign load    = rs.rdy && drain && |ready;
    assign acc     = rs.rdy && rs.disp_en && !rs.full;

    always_ff @(posedge clk)
        if (!rst || rs.flush) begin
            busy         <= '0;
            rs.count     <= '0;
            rs.iss_valid <= 1'b0;
            rs.iss_op    <= '0;
            rs.iss_v1    <= '0;
            rs.iss_v2    <= '0;
            rs.iss_pc    <= '0;
            rs.iss_imm   <= '0;
            rs.iss_rob   <= '0;
        end else if (rs.rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && w1[i][32]) begin
                    e_v1[i] <= w1[i][31:0];
                    e_q1[i] <= '0;
                end
                if (busy[i] && w2[i][32]) begin
                    e_v2[i] <= w2[i][31:0];
                    e_q2[i] <= '0;
                end
            end
            if (load) begin
                busy[sel]    <= 1'b0;
                rs.iss_valid <= 1'b1;
                rs.iss_op    <= e_op[sel];
                rs.iss_v1    <= e_v1[sel];
                rs.iss_v2    <= e_v2[sel];
                rs.iss_pc    <= e_pc[sel];
                rs.iss_imm   <= e_imm[sel];
                rs.iss_rob   <= e_rob[sel];
            end else if (drain) rs.iss_valid <= 1'b0;
            if (acc) begin
                busy[fs]  <= 1'b1;
                e_op[fs]  <= rs.disp_op;
                e_v1[fs]  <= b1[32] ? b1[31:0] : rs.disp_v1;
                e_q1[fs]  <= b1[32] ? '0 : rs.disp_q1;
                e_v2[fs]  <= b2[32] ? b2[31:0] : rs.disp_v2;
                e_q2[fs]  <= b2[32] ? '0 : rs.disp_q2;
                e_pc[fs]  <= rs.disp_pc;
                e_imm[fs] <= rs.disp_imm;
                e_rob[fs] <= rs.disp_rob;
            end
            rs.count <= rs.count + CW'(acc) - CW'(load);
        end
endmodule
